// File: rtl/iir_filter_sequencer.sv
// Sequencer for the shared stereo IIR datapath: walks one L/R sample pair through the taps
// and returns saturated results. Coefficients are double-buffered and only swap between samples.
module iir_filter_sequencer #(
    parameter int NTAPS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_l,
    input  logic [15:0]           in_r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_l,
    output logic [15:0]           out_r,
    input  logic                  cfg_we,
    input  logic [1:0]            cfg_tap,
    input  logic [7:0]            cfg_cx,
    input  logic [23:0]           cfg_cy,
    input  logic                  cfg_commit,
    output logic                  tap_ce,
    output logic                  tap_ch,
    output logic [39:0]           tap_x,
    output logic [39:0]           tap_y,
    output logic [NTAPS*8-1:0]    tap_cx,
    output logic [NTAPS*24-1:0]   tap_cy,
    input  logic [39:0]           filt_y
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL_L,
        S_UPD_L,
        S_EVAL_R,
        S_UPD_R,
        S_OUT
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q;
    logic [15:0] samp_l_q, samp_l_d, samp_r_q, samp_r_d;
    logic [39:0] y_l_q, y_l_d, y_r_q, y_r_d;
    logic [39:0] tap_x_q, tap_x_d, tap_y_q, tap_y_d;
    logic        tap_ch_q, tap_ch_d;
    logic [15:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic        commit_pending_q, commit_pending_d;
    logic        copy_en;

    function automatic logic [39:0] ext(input logic [15:0] s);
        return {{4{s[15]}}, s, 20'b0};
    endfunction

    // Integer part lives in y[35:20]; anything spilling into y[39:36] saturates.
    function automatic logic [15:0] sat16(input logic [39:0] y);
        if (y[39:35] == 5'b00000 || y[39:35] == 5'b11111) begin
            return y[35:20];
        end else if (y[39]) begin
            return 16'h8000;
        end else begin
            return 16'h7FFF;
        end
    endfunction

    always_comb begin
        state_d          = state_q;
        samp_l_d         = samp_l_q;
        samp_r_d         = samp_r_q;
        y_l_d            = y_l_q;
        y_r_d            = y_r_q;
        tap_x_d          = tap_x_q;
        tap_y_d          = tap_y_q;
        tap_ch_d         = tap_ch_q;
        out_l_d          = out_l_q;
        out_r_d          = out_r_q;
        commit_pending_d = commit_pending_q | cfg_commit;
        copy_en          = 1'b0;

        if (state_q == S_IDLE && commit_pending_d) begin
            copy_en          = 1'b1;
            commit_pending_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && ready_q) begin
                    samp_l_d = in_l;
                    samp_r_d = in_r;
                    tap_x_d  = ext(in_l);
                    tap_ch_d = 1'b0;
                    state_d  = S_EVAL_L;
                end
            end
            S_EVAL_L: begin
                y_l_d   = filt_y;
                tap_y_d = filt_y;
                state_d = S_UPD_L;
            end
            S_UPD_L: begin
                tap_x_d  = ext(samp_r_q);
                tap_ch_d = 1'b1;
                state_d  = S_EVAL_R;
            end
            S_EVAL_R: begin
                y_r_d   = filt_y;
                tap_y_d = filt_y;
                state_d = S_UPD_R;
            end
            S_UPD_R: begin
                out_l_d = sat16(y_l_q);
                out_r_d = sat16(y_r_q);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            ready_q          <= 1'b0;
            samp_l_q         <= '0;
            samp_r_q         <= '0;
            y_l_q            <= '0;
            y_r_q            <= '0;
            tap_x_q          <= '0;
            tap_y_q          <= '0;
            tap_ch_q         <= 1'b0;
            out_l_q          <= '0;
            out_r_q          <= '0;
            commit_pending_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            ready_q          <= 1'b1;
            samp_l_q         <= samp_l_d;
            samp_r_q         <= samp_r_d;
            y_l_q            <= y_l_d;
            y_r_q            <= y_r_d;
            tap_x_q          <= tap_x_d;
            tap_y_q          <= tap_y_d;
            tap_ch_q         <= tap_ch_d;
            out_l_q          <= out_l_d;
            out_r_q          <= out_r_d;
            commit_pending_q <= commit_pending_d;
        end
    end

    // The active copy takes next-shadow so a same-cycle write is included in the commit.
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
        logic [31:0] shadow_q, shadow_d, active_q, active_d;

        always_comb begin
            shadow_d = shadow_q;
            if (cfg_we && (int'(cfg_tap) == gi)) begin
                shadow_d = {cfg_cx, cfg_cy};
            end
            active_d = copy_en ? shadow_d : active_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                shadow_q <= '0;
                active_q <= '0;
            end else begin
                shadow_q <= shadow_d;
                active_q <= active_d;
            end
        end

        assign tap_cx[8*gi +: 8]   = active_q[31:24];
        assign tap_cy[24*gi +: 24] = active_q[23:0];
    end

    assign in_ready  = ready_q && (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign tap_ce    = (state_q == S_UPD_L) || (state_q == S_UPD_R);
    assign tap_ch    = tap_ch_q;
    assign tap_x     = tap_x_q;
    assign tap_y     = tap_y_q;

endmodule

// File: tb/tb_iir_filter_sequencer.sv
// Directed bench for iir_filter_sequencer: a single-tap x*cx/16 model stands in for the taps,
// and a scoreboard monitor checks every output pair together with its latency.
module tb_iir_filter_sequencer;

    localparam int NTAPS = 3;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [15:0]          in_l, in_r, out_l, out_r;
    logic                 cfg_we, cfg_commit;
    logic [1:0]           cfg_tap;
    logic [7:0]           cfg_cx;
    logic [23:0]          cfg_cy;
    logic                 tap_ce, tap_ch;
    logic [39:0]          tap_x, tap_y, filt_y;
    logic [NTAPS*8-1:0]   tap_cx;
    logic [NTAPS*24-1:0]  tap_cy;

    logic                 force_en;
    logic [39:0]          force_val;
    logic signed [47:0]   prod;

    always #5 clk = ~clk;

    iir_filter_sequencer #(.NTAPS(NTAPS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_l       (in_l),
        .in_r       (in_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_l      (out_l),
        .out_r      (out_r),
        .cfg_we     (cfg_we),
        .cfg_tap    (cfg_tap),
        .cfg_cx     (cfg_cx),
        .cfg_cy     (cfg_cy),
        .cfg_commit (cfg_commit),
        .tap_ce     (tap_ce),
        .tap_ch     (tap_ch),
        .tap_x      (tap_x),
        .tap_y      (tap_y),
        .tap_cx     (tap_cx),
        .tap_cy     (tap_cy),
        .filt_y     (filt_y)
    );

    // Tap 0 only: y = x * cx0 / 16, so cx0 = 4 gives x/4.
    assign prod   = $signed(tap_x) * $signed(tap_cx[7:0]);
    assign filt_y = force_en ? force_val : 40'(prod >>> 4);

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    typedef struct {
        int   cyc;
        logic ch;
    } ce_t;

    exp_t exp_q[$];
    ce_t  ce_log[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_pop_cyc = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
        end else begin
            if (tap_ce) ce_log.push_back('{cyc, tap_ch});
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: out_valid=1 at cycle %0d, scoreboard empty", cyc);
                end else begin
                    check("latency", 80'(cyc), 80'(exp_q[0].cyc));
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                $display("out pair l=%h r=%h at cycle %0d", out_l, out_r, cyc);
                check("out_l", 80'(out_l), 80'(mon_e.l));
                check("out_r", 80'(out_r), 80'(mon_e.r));
                last_pop_cyc <= cyc;
            end
            prev_valid <= out_valid;
        end
    end

    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] el, input logic [15:0] er, output int acc);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        in_l = l;
        in_r = r;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
            acc = -1;
        end else begin
            acc = cyc;
            exp_q.push_back('{el, er, cyc + 5});
            $display("in pair l=%h r=%h accepted at cycle %0d", l, r, cyc);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_ce(input int acc);
        check("ce_count", 80'(ce_log.size()), 80'(2));
        if (ce_log.size() >= 2) begin
            check("ce0_cycle", 80'(ce_log[0].cyc), 80'(acc + 2));
            check("ce0_ch", 80'(ce_log[0].ch), 80'(0));
            check("ce1_cycle", 80'(ce_log[1].cyc), 80'(acc + 4));
            check("ce1_ch", 80'(ce_log[1].ch), 80'(1));
        end
        ce_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc_b, guard;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_l = '0;
        in_r = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_tap = '0;
        cfg_cx = '0;
        cfg_cy = '0;
        cfg_commit = 1'b0;
        force_en = 1'b0;
        force_val = '0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 80'(in_ready), 80'(0));
        check("rst_out_valid", 80'(out_valid), 80'(0));
        check("rst_tap_ce", 80'(tap_ce), 80'(0));
        check("rst_tap_ch", 80'(tap_ch), 80'(0));
        check("rst_tap_x", 80'(tap_x), 80'(0));
        check("rst_tap_y", 80'(tap_y), 80'(0));
        check("rst_out_lr", 80'({out_l, out_r}), 80'(0));
        check("rst_tap_cx", 80'(tap_cx), 80'(0));
        check("rst_tap_cy", 80'(tap_cy), 80'(0));

        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_in_ready", 80'(in_ready), 80'(1));
        check("idle_out_valid", 80'(out_valid), 80'(0));
        check("idle_no_ce", 80'(ce_log.size()), 80'(0));

        // Same-cycle write + commit in IDLE
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_tap = 2'd0; cfg_cx = 8'h04; cfg_cy = 24'h123456; cfg_commit = 1'b1;
        @(negedge clk);
        check("cx_before_commit", 80'(tap_cx), 80'(0));
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        @(negedge clk);
        check("cx_after_commit", 80'(tap_cx), 80'(24'h000004));
        check("cy_after_commit", 80'(tap_cy), 80'(72'h123456));

        // Out-of-range slot is ignored
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_tap = 2'd3; cfg_cx = 8'hFF; cfg_cy = 24'hFFFFFF; cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        @(negedge clk);
        check("cx_tap3_ignored", 80'(tap_cx), 80'(24'h000004));
        check("cy_tap3_ignored", 80'(tap_cy), 80'(72'h123456));

        // Basic x/4 sample
        send(16'h4000, 16'hC000, 16'h1000, 16'hF000, acc);
        drain();
        check_ce(acc);

        // Saturation
        force_en = 1'b1;
        force_val = 40'h7F_0000_0000;
        send(16'h1234, 16'h1234, 16'h7FFF, 16'h7FFF, acc);
        drain();
        check_ce(acc);
        force_val = 40'h80_0000_0000;
        send(16'h1234, 16'h1234, 16'h8000, 16'h8000, acc);
        drain();
        check_ce(acc);
        force_en = 1'b0;

        // Output backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'h0400, 16'hFC00, 16'h0100, 16'hFF00, acc);
        in_l = 16'h2000;
        in_r = 16'h8000;
        in_valid = 1'b1;
        guard = 0;
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (10) begin
            @(negedge clk);
            check("stall_in_ready", 80'(in_ready), 80'(0));
            check("stall_out_l", 80'(out_l), 80'(16'h0100));
        end
        check_ce(acc);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h2000, 16'h8000, 16'h0800, 16'hE000, acc_b);
        check("accept_after_release", 80'(acc_b), 80'(last_pop_cyc + 1));
        drain();
        check_ce(acc_b);

        // Commit mid-sample waits for IDLE
        send(16'h4000, 16'hC000, 16'h1000, 16'hF000, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_tap = 2'd0; cfg_cx = 8'h08; cfg_cy = 24'h0ABCDE; cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0;
        @(negedge clk);
        check("cx_hold_upd_r", 80'(tap_cx), 80'(24'h000004));
        @(negedge clk);
        check("cx_hold_out", 80'(tap_cx), 80'(24'h000004));
        @(negedge clk);
        check("cy_hold_idle", 80'(tap_cy), 80'(72'h123456));
        @(negedge clk);
        check("cx_new_after_idle", 80'(tap_cx), 80'(24'h000008));
        check("cy_new_after_idle", 80'(tap_cy), 80'(72'h0ABCDE));
        drain();
        check_ce(acc);
        send(16'h1000, 16'hF000, 16'h0800, 16'hF800, acc);
        drain();
        check_ce(acc);

        // Reset during UPD_L aborts the sample
        send(16'h4000, 16'hC000, 16'h1000, 16'hF000, acc);
        @(posedge clk); #1;
        check("ce_in_upd_l", 80'(tap_ce), 80'(1));
        reset_n = 1'b0;
        #1;
        check("abort_tap_ce", 80'(tap_ce), 80'(0));
        check("abort_out_valid", 80'(out_valid), 80'(0));
        check("abort_tap_cx", 80'(tap_cx), 80'(0));
        check("abort_tap_cy", 80'(tap_cy), 80'(0));
        check("abort_in_ready", 80'(in_ready), 80'(0));
        exp_q.delete();
        ce_log.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_abort_no_ce", 80'(ce_log.size()), 80'(0));
        check("post_abort_in_ready", 80'(in_ready), 80'(1));
        check("post_abort_out_valid", 80'(out_valid), 80'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
